// File: rtl/input_debounce_sync.sv
// Per-channel input conditioner: multi-flop synchroniser followed by a
// four-state debounce FSM that drives a clean level plus rise/fall pulses.
module input_debounce_sync #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_WAIT,
        S_HIGH,
        S_FALL_WAIT
    } state_t;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   syn;
            state_t                 state_reg, state_next;
            logic [CNT_W-1:0]       cnt_reg, cnt_next;
            logic                   clean_reg, clean_next;
            logic                   rise_reg, rise_next;
            logic                   fall_reg, fall_next;

            assign syn = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_reg  <= '0;
                    state_reg <= S_LOW;
                    cnt_reg   <= '0;
                    clean_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    clean_reg <= clean_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

            // A return to the old level always wins over completion, so a
            // bounce on the final qualifying cycle is still rejected.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                clean_next = clean_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                case (state_reg)
                    S_LOW: begin
                        if (syn) begin
                            state_next = S_RISE_WAIT;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    S_RISE_WAIT: begin
                        if (!syn) begin
                            state_next = S_LOW;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = S_HIGH;
                            cnt_next   = '0;
                            clean_next = 1'b1;
                            rise_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    S_HIGH: begin
                        if (!syn) begin
                            state_next = S_FALL_WAIT;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    S_FALL_WAIT: begin
                        if (syn) begin
                            state_next = S_HIGH;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = S_LOW;
                            cnt_next   = '0;
                            clean_next = 1'b0;
                            fall_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = S_LOW;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign clean_out[gi]  = clean_reg;
            assign rise_pulse[gi] = rise_reg;
            assign fall_pulse[gi] = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed bench for input_debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4:
// a raw change first sampled at edge 0 shows on clean_out after edge 5.
module tb_input_debounce_sync;

    logic       clk;
    logic       rst_n;
    logic [1:0] raw_in;
    logic [1:0] clean_out;
    logic [1:0] rise_pulse;
    logic [1:0] fall_pulse;

    int checks   = 0;
    int failures = 0;

    input_debounce_sync #(
        .WIDTH          (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] c, input logic [1:0] r,
                           input logic [1:0] f);
        chk({tag, ".clean"}, clean_out, c);
        chk({tag, ".rise"}, rise_pulse, r);
        chk({tag, ".fall"}, fall_pulse, f);
    endtask

    initial begin
        rst_n  = 1'b0;
        raw_in = 2'b11;

        // Reset held for three edges with inputs high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("rst_hold%0d", i), 2'b00, 2'b00, 2'b00);
        end
        rst_n = 1'b1;

        // Release: both channels qualify together after edge 5
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all($sformatf("rel_rise%0d", i), (i >= 5) ? 2'b11 : 2'b00,
                    (i == 5) ? 2'b11 : 2'b00, 2'b00);
        end

        // Both raw bits drop on the same edge: simultaneous falls
        raw_in = 2'b00;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all($sformatf("both_fall%0d", i), (i >= 5) ? 2'b00 : 2'b11, 2'b00,
                    (i == 5) ? 2'b11 : 2'b00);
        end

        // Channel 0 rises alone
        raw_in = 2'b01;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all($sformatf("ch0_rise%0d", i), (i >= 5) ? 2'b01 : 2'b00,
                    (i == 5) ? 2'b01 : 2'b00, 2'b00);
        end

        // Channel 1 high for only three edges: bounce rejected
        raw_in = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("ch1_bounce_hi%0d", i), 2'b01, 2'b00, 2'b00);
        end
        raw_in = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all($sformatf("ch1_bounce_lo%0d", i), 2'b01, 2'b00, 2'b00);
        end

        // Channel 1 held high: qualification starts again from zero
        raw_in = 2'b11;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all($sformatf("ch1_rise%0d", i), (i >= 5) ? 2'b11 : 2'b01,
                    (i == 5) ? 2'b10 : 2'b00, 2'b00);
        end

        // Bring channel 0 low so it can be caught mid-qualification
        raw_in = 2'b10;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all($sformatf("ch0_fall%0d", i), (i >= 5) ? 2'b10 : 2'b11, 2'b00,
                    (i == 5) ? 2'b01 : 2'b00);
        end

        // Channel 0 rises; after four edges it is in rise-wait with cnt=2
        raw_in = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("ch0_pend%0d", i), 2'b10, 2'b00, 2'b00);
        end
        rst_n = 1'b0;
        tick();
        chk_all("mid_reset", 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;

        // Pending qualification abandoned: full latency again on both channels
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all($sformatf("post_reset%0d", i), (i >= 5) ? 2'b11 : 2'b00,
                    (i == 5) ? 2'b11 : 2'b00, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
